// File: rtl/aes_pkg.sv
// Shared AES constants: key-length encodings, NK/NR lookup, rcon seed and xtime.
package aes_pkg;

    typedef enum logic [1:0] {
        KL_128 = 2'b00,
        KL_192 = 2'b01,
        KL_256 = 2'b10,
        KL_BAD = 2'b11
    } key_len_e;

    typedef enum logic {
        ST_IDLE,
        ST_EXPAND
    } sched_state_e;

    localparam int         ROUND_KEY_W = 128;
    localparam logic [7:0] RCON_INIT   = 8'h01;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nk_of(input key_len_e kl);
        case (kl)
            KL_192:  return NK_192;
            KL_256:  return NK_256;
            default: return NK_128;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_e kl);
        case (kl)
            KL_192:  return NR_192;
            KL_256:  return NR_256;
            default: return NR_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box (forward), shared between key schedule and SubBytes.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Byte for input a sits at bits [(255-a)*8 +: 8]; 255-a is ~a for 8 bits.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_sched_iter.sv
// Iterative AES-128/192/256 key schedule: one expanded word per clock into a round-key store.
// AES-256 support (8-word window, j==4 SubWord) is built only with AES_KEY_SCHED_256_EN.
module aes_key_sched_iter
    import aes_pkg::*;
#(
    parameter int MAX_NR = 14,
    parameter int RK_AW  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             key_len,
    input  logic [255:0]           key,
    output logic                   busy,
    output logic                   done,
    output logic                   key_valid,
    output logic                   err,
    output logic [3:0]             nr,
    input  logic [RK_AW-1:0]       rk_rd_addr,
    output logic [ROUND_KEY_W-1:0] rk_rd_data
);

`ifdef AES_KEY_SCHED_256_EN
    localparam int WIN     = 8;
    localparam int EFF_NR  = MAX_NR;
    localparam bit HAS_256 = 1'b1;
`else
    localparam int WIN     = 6;
    localparam int EFF_NR  = 12;
    localparam bit HAS_256 = 1'b0;
    localparam int unused_max_nr = MAX_NR;
    logic unused_key;
    assign unused_key = ^key[63:0];
`endif

    localparam int DEPTH_W = 4 * (EFF_NR + 1);
    localparam int IDX_W   = 6;

    sched_state_e     state_q, state_d;
    logic [31:0]      key_w [WIN];
    logic [31:0]      win   [WIN];
    logic [31:0]      mem   [DEPTH_W];
    logic [IDX_W-1:0] i_q, last_q, rd_base;
    logic [2:0]       j_q, nkm1_q;
    logic [7:0]       rcon_q;
    logic [3:0]       nr_q;
    logic             done_q, valid_q, err_q;
    logic [127:0]     rd_q;

    key_len_e    kl;
    logic        legal, accept, reject, last, in_key;
    logic [31:0] w_im1, w_imnk, sb_in, sb_out, temp, w_new;

    assign kl     = key_len_e'(key_len);
    assign in_key = (i_q <= {3'b000, nkm1_q});
    assign last   = (state_q == ST_EXPAND) && (i_q == last_q);
    assign accept = (state_q == ST_IDLE) && start && legal;
    assign reject = (state_q == ST_IDLE) && start && !legal;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        legal   = 1'b0;
        state_d = state_q;
        case (kl)
            KL_128, KL_192: legal = 1'b1;
            KL_256:         legal = HAS_256;
            default:        legal = 1'b0;
        endcase
        if (accept)    state_d = ST_EXPAND;
        else if (last) state_d = ST_IDLE;
    end

    // Window slot 0 is w[i-1]; slot NK-1 is w[i-NK].
    assign w_im1  = win[0];
    assign w_imnk = win[nkm1_q];
    assign sb_in  = (j_q == 3'd0) ? {w_im1[23:0], w_im1[31:24]} : w_im1;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (sb_in[8*g +: 8]),
            .y (sb_out[8*g +: 8])
        );
    end

    always_comb begin
        temp = w_im1;
        if (j_q == 3'd0)
            temp = sb_out ^ {rcon_q, 24'h0};
`ifdef AES_KEY_SCHED_256_EN
        else if (nkm1_q == 3'd7 && j_q == 3'd4)
            temp = sb_out;
`endif
        w_new = in_key ? key_w[i_q[2:0]] : (temp ^ w_imnk);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            nkm1_q  <= '0;
            last_q  <= '0;
            rcon_q  <= RCON_INIT;
            nr_q    <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= last;
            err_q   <= reject;
            if (accept) begin
                nkm1_q  <= 3'(nk_of(kl) - 4'd1);
                nr_q    <= nr_of(kl);
                last_q  <= {nr_of(kl), 2'b00} + IDX_W'(3);
                i_q     <= '0;
                j_q     <= '0;
                rcon_q  <= RCON_INIT;
                valid_q <= 1'b0;
            end else if (state_q == ST_EXPAND) begin
                i_q <= i_q + IDX_W'(1);
                j_q <= (j_q == nkm1_q) ? 3'd0 : j_q + 3'd1;
                if (j_q == 3'd0 && !in_key)
                    rcon_q <= xtime(rcon_q);
                if (last)
                    valid_q <= 1'b1;
            end
        end
    end

    // NOTE: key latch, word window and store are not reset; their contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < WIN; k++)
                key_w[k] <= key[255-32*k -: 32];
        end
        if (state_q == ST_EXPAND) begin
            win[0] <= w_new;
            for (int k = 1; k < WIN; k++)
                win[k] <= win[k-1];
            mem[i_q] <= w_new;
        end
    end

    assign rd_base = IDX_W'({rk_rd_addr, 2'b00});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_q <= '0;
        else if (32'(rk_rd_addr) > 32'(nr_q))
            rd_q <= '0;
        else
            rd_q <= {mem[rd_base], mem[rd_base + IDX_W'(1)],
                     mem[rd_base + IDX_W'(2)], mem[rd_base + IDX_W'(3)]};
    end

    assign busy       = (state_q == ST_EXPAND);
    assign done       = done_q;
    assign key_valid  = valid_q;
    assign err        = err_q;
    assign nr         = nr_q;
    assign rk_rd_data = rd_q;

endmodule
